// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer with in-order retire,
// out-of-order writeback capture and branch/jalr flush generation.
module rob_commit #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        issue_valid,
   input  logic [4:0]  issue_dest,
   input  logic        issue_is_branch,
   input  logic        issue_is_jalr,
   input  logic        issue_pred_jump,
   output logic [3:0]  issue_rename,
   output logic        rob_full,
   input  logic        wb_valid,
   input  logic [3:0]  wb_rename,
   input  logic [31:0] wb_value,
   output logic        commit_flag,
   output logic [31:0] commit_value,
   output logic [3:0]  commit_rename,
   output logic [4:0]  commit_dest,
   output logic        commit_is_branch,
   output logic        commit_is_jalr,
   output logic        flush
);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] ready_q, ready_d;
   logic [DEPTH-1:0] isbr_q, isbr_d;
   logic [DEPTH-1:0] isjalr_q, isjalr_d;
   logic [DEPTH-1:0] pred_q, pred_d;
   logic [4:0]       dest_q [DEPTH];
   logic [4:0]       dest_d [DEPTH];
   logic [31:0]      value_q [DEPTH];
   logic [31:0]      value_d [DEPTH];

   logic [3:0]  head_q, head_d;
   logic [3:0]  tail_q, tail_d;
   logic [4:0]  count_q, count_d;

   logic        cflag_q, cflag_d;
   logic        flush_q, flush_d;
   logic [31:0] cvalue_q, cvalue_d;
   logic [3:0]  crename_q, crename_d;
   logic [4:0]  cdest_q, cdest_d;
   logic        cbr_q, cbr_d;
   logic        cjalr_q, cjalr_d;

   logic full;
   logic alloc;
   logic wb_en;
   logic commit_en;
   logic mispred;

   assign full         = (count_q == 5'(DEPTH));
   assign rob_full     = full;
   assign issue_rename = tail_q;

   assign alloc     = issue_valid && !full && rdy && !flush_q;
   assign wb_en     = wb_valid && rdy && busy_q[wb_rename] && !flush_q;
   assign commit_en = (count_q != 5'd0) && busy_q[head_q] &&
                      ready_q[head_q] && rdy && !flush_q;

   // Any jalr redirects; a branch redirects only on a wrong guess.
   assign mispred = (isbr_q[head_q] &&
                     (value_q[head_q][0] != pred_q[head_q])) ||
                    isjalr_q[head_q];

   always_comb begin
      busy_d    = busy_q;
      ready_d   = ready_q;
      isbr_d    = isbr_q;
      isjalr_d  = isjalr_q;
      pred_d    = pred_q;
      dest_d    = dest_q;
      value_d   = value_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      cflag_d   = 1'b0;
      flush_d   = 1'b0;
      cvalue_d  = cvalue_q;
      crename_d = crename_q;
      cdest_d   = cdest_q;
      cbr_d     = cbr_q;
      cjalr_d   = cjalr_q;
      if (flush_q) begin
         busy_d  = '0;
         head_d  = 4'd0;
         tail_d  = 4'd0;
         count_d = 5'd0;
      end else begin
         if (wb_en) begin
            value_d[wb_rename] = wb_value;
            ready_d[wb_rename] = 1'b1;
         end
         if (alloc) begin
            busy_d[tail_q]   = 1'b1;
            ready_d[tail_q]  = 1'b0;
            dest_d[tail_q]   = issue_dest;
            isbr_d[tail_q]   = issue_is_branch;
            isjalr_d[tail_q] = issue_is_jalr;
            pred_d[tail_q]   = issue_pred_jump;
            tail_d           = tail_q + 4'd1;
         end
         if (commit_en) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 4'd1;
            cflag_d        = 1'b1;
            flush_d        = mispred;
            cvalue_d       = value_q[head_q];
            crename_d      = head_q;
            cdest_d        = dest_q[head_q];
            cbr_d          = isbr_q[head_q];
            cjalr_d        = isjalr_q[head_q];
         end
         count_d = count_q + 5'(alloc) - 5'(commit_en);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q    <= '0;
         ready_q   <= '0;
         isbr_q    <= '0;
         isjalr_q  <= '0;
         pred_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i]  <= 5'd0;
            value_q[i] <= 32'd0;
         end
         head_q    <= 4'd0;
         tail_q    <= 4'd0;
         count_q   <= 5'd0;
         cflag_q   <= 1'b0;
         flush_q   <= 1'b0;
         cvalue_q  <= 32'd0;
         crename_q <= 4'd0;
         cdest_q   <= 5'd0;
         cbr_q     <= 1'b0;
         cjalr_q   <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         isbr_q    <= isbr_d;
         isjalr_q  <= isjalr_d;
         pred_q    <= pred_d;
         dest_q    <= dest_d;
         value_q   <= value_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         cflag_q   <= cflag_d;
         flush_q   <= flush_d;
         cvalue_q  <= cvalue_d;
         crename_q <= crename_d;
         cdest_q   <= cdest_d;
         cbr_q     <= cbr_d;
         cjalr_q   <= cjalr_d;
      end
   end

   assign commit_flag      = cflag_q;
   assign flush            = flush_q;
   assign commit_value     = cvalue_q;
   assign commit_rename    = crename_q;
   assign commit_dest      = cdest_q;
   assign commit_is_branch = cbr_q;
   assign commit_is_jalr   = cjalr_q;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed vector table, corner sequences and random
// traffic checked against a program-order queue model of the ROB.
module tb_rob_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        issue_valid;
   logic [4:0]  issue_dest;
   logic        issue_is_branch;
   logic        issue_is_jalr;
   logic        issue_pred_jump;
   logic [3:0]  issue_rename;
   logic        rob_full;
   logic        wb_valid;
   logic [3:0]  wb_rename;
   logic [31:0] wb_value;
   logic        commit_flag;
   logic [31:0] commit_value;
   logic [3:0]  commit_rename;
   logic [4:0]  commit_dest;
   logic        commit_is_branch;
   logic        commit_is_jalr;
   logic        flush;

   always #5 clk = ~clk;

   rob_commit #(.DEPTH(16)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_dest(issue_dest),
      .issue_is_branch(issue_is_branch), .issue_is_jalr(issue_is_jalr),
      .issue_pred_jump(issue_pred_jump), .issue_rename(issue_rename),
      .rob_full(rob_full), .wb_valid(wb_valid), .wb_rename(wb_rename),
      .wb_value(wb_value), .commit_flag(commit_flag),
      .commit_value(commit_value), .commit_rename(commit_rename),
      .commit_dest(commit_dest), .commit_is_branch(commit_is_branch),
      .commit_is_jalr(commit_is_jalr), .flush(flush)
   );

   typedef struct {
      logic        iv;
      logic [4:0]  d;
      logic        br;
      logic        jalr;
      logic        pred;
      logic        wbv;
      logic [3:0]  wt;
      logic [31:0] wv;
      logic        rdy;
   } in_t;

   typedef struct {
      logic        do_rst;
      in_t         i;
      logic        ef;
      logic [3:0]  er;
      logic [4:0]  ed;
      logic [31:0] ev;
      logic        efl;
   } vec_t;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dest;
      logic        br;
      logic        jalr;
      logic        pred;
      logic        done;
      logic [31:0] val;
   } ent_t;

   int checks = 0;
   int errors = 0;

   ent_t        q[$];
   logic [3:0]  m_tail;
   logic        m_flag, m_flush, m_br, m_jalr;
   logic [31:0] m_val;
   logic [3:0]  m_ren;
   logic [4:0]  m_dest;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic in_t mk(logic iv, logic [4:0] d, logic br,
                              logic jalr, logic pred, logic wbv,
                              logic [3:0] wt, logic [31:0] wv,
                              logic r);
      in_t x;
      x.iv = iv; x.d = d; x.br = br; x.jalr = jalr; x.pred = pred;
      x.wbv = wbv; x.wt = wt; x.wv = wv; x.rdy = r;
      return x;
   endfunction

   function automatic in_t idle();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endfunction

   function automatic in_t iss(logic [4:0] d, logic br, logic jalr,
                               logic pred);
      return mk(1, d, br, jalr, pred, 0, 0, 0, 1);
   endfunction

   function automatic in_t wb(logic [3:0] t, logic [31:0] v);
      return mk(0, 0, 0, 0, 0, 1, t, v, 1);
   endfunction

   task automatic m_clear();
      q.delete();
      m_tail = 0; m_flag = 0; m_flush = 0; m_br = 0; m_jalr = 0;
      m_val = 0; m_ren = 0; m_dest = 0;
   endtask

   // One clock edge of ROB behaviour, from program-order rules.
   task automatic m_step(input in_t i);
      ent_t h;
      ent_t e;
      int   n;
      logic do_c;
      if (m_flush) begin
         q.delete();
         m_tail = 0; m_flag = 0; m_flush = 0;
      end else if (!i.rdy) begin
         m_flag = 0; m_flush = 0;
      end else begin
         n = q.size();
         do_c = (n > 0) && q[0].done;
         if (n > 0) h = q[0];
         if (i.wbv)
            foreach (q[k]) if (q[k].tag == i.wt) begin
               q[k].done = 1; q[k].val = i.wv;
            end
         if (do_c) begin
            m_flag = 1; m_val = h.val; m_ren = h.tag; m_dest = h.dest;
            m_br = h.br; m_jalr = h.jalr;
            m_flush = h.jalr || (h.br && (h.val[0] != h.pred));
            void'(q.pop_front());
         end else begin
            m_flag = 0; m_flush = 0;
         end
         if (i.iv && n < 16) begin
            e.tag = m_tail; e.dest = i.d; e.br = i.br; e.jalr = i.jalr;
            e.pred = i.pred; e.done = 0; e.val = 0;
            q.push_back(e);
            m_tail = m_tail + 4'd1;
         end
      end
   endtask

   task automatic step(input in_t i);
      @(negedge clk);
      issue_valid = i.iv; issue_dest = i.d; issue_is_branch = i.br;
      issue_is_jalr = i.jalr; issue_pred_jump = i.pred;
      wb_valid = i.wbv; wb_rename = i.wt; wb_value = i.wv; rdy = i.rdy;
      #1;
      chk("issue_rename", issue_rename, m_tail);
      chk("rob_full", rob_full, q.size() == 16);
      @(posedge clk);
      m_step(i);
      #1;
      chk("commit_flag", commit_flag, m_flag);
      chk("flush", flush, m_flush);
      if (m_flag) begin
         chk("commit_value", commit_value, m_val);
         chk("commit_rename", commit_rename, m_ren);
         chk("commit_dest", commit_dest, m_dest);
         chk("commit_is_branch", commit_is_branch, m_br);
         chk("commit_is_jalr", commit_is_jalr, m_jalr);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      issue_valid = 0; wb_valid = 0; rdy = 1;
      #1 rst = 0;
      #1;
      m_clear();
      chk("rst_flag", commit_flag, 0);
      chk("rst_flush", flush, 0);
      chk("rst_value", commit_value, 0);
      chk("rst_rename", commit_rename, 0);
      chk("rst_dest", commit_dest, 0);
      chk("rst_br_jalr", {commit_is_branch, commit_is_jalr}, 0);
      chk("rst_tail", issue_rename, 0);
      chk("rst_full", rob_full, 0);
      @(negedge clk);
      rst = 1;
   endtask

   vec_t tbl[14];

   initial begin
      rst = 1; rdy = 1; issue_valid = 0; issue_dest = 0;
      issue_is_branch = 0; issue_is_jalr = 0; issue_pred_jump = 0;
      wb_valid = 0; wb_rename = 0; wb_value = 0;
      m_clear();

      foreach (tbl[k]) begin
         tbl[k].do_rst = 0; tbl[k].i = idle(); tbl[k].ef = 0;
         tbl[k].er = 0; tbl[k].ed = 0; tbl[k].ev = 0; tbl[k].efl = 0;
      end
      tbl[0].do_rst = 1; tbl[0].i = iss(5, 0, 0, 0);
      tbl[1].i = wb(0, 32'hAA);
      tbl[2].ef = 1; tbl[2].er = 0; tbl[2].ed = 5; tbl[2].ev = 32'hAA;
      tbl[4].do_rst = 1; tbl[4].i = iss(1, 0, 0, 0);
      tbl[5].i = iss(2, 0, 0, 0);
      tbl[6].i = iss(3, 0, 0, 0);
      tbl[7].i = wb(2, 32'h22);
      tbl[8].i = wb(1, 32'h11);
      tbl[9].i = wb(0, 32'h10);
      tbl[10].ef = 1; tbl[10].er = 0; tbl[10].ed = 1; tbl[10].ev = 32'h10;
      tbl[11].ef = 1; tbl[11].er = 1; tbl[11].ed = 2; tbl[11].ev = 32'h11;
      tbl[12].ef = 1; tbl[12].er = 2; tbl[12].ed = 3; tbl[12].ev = 32'h22;

      for (int k = 0; k < 14; k++) begin
         if (tbl[k].do_rst) do_reset();
         step(tbl[k].i);
         chk($sformatf("tbl%0d_flag", k), commit_flag, tbl[k].ef);
         chk($sformatf("tbl%0d_flush", k), flush, tbl[k].efl);
         if (tbl[k].ef) begin
            chk($sformatf("tbl%0d_rename", k), commit_rename, tbl[k].er);
            chk($sformatf("tbl%0d_dest", k), commit_dest, tbl[k].ed);
            chk($sformatf("tbl%0d_value", k), commit_value, tbl[k].ev);
         end
      end

      // full and wrap
      do_reset();
      for (int k = 0; k < 16; k++) step(iss(5'(k + 1), 0, 0, 0));
      #1 chk("full_after_16", rob_full, 1);
      step(iss(31, 0, 0, 0));
      chk("full_17th_ignored", rob_full, 1);
      step(wb(0, 32'h55));
      step(idle());
      chk("full_commit_tag0", commit_rename, 0);
      chk("full_cleared", rob_full, 0);
      chk("wrap_rename", issue_rename, 0);
      step(iss(7, 0, 0, 0));
      for (int k = 1; k < 16; k++) step(wb(4'(k), 32'(k)));
      step(wb(0, 32'h77));
      for (int k = 0; k < 18; k++) step(idle());
      chk("wrap_drained", rob_full, 0);

      // branch mispredict
      do_reset();
      step(iss(0, 1, 0, 0));
      step(iss(8, 0, 0, 0));
      step(iss(9, 0, 0, 0));
      step(wb(1, 32'h1));
      step(wb(2, 32'h2));
      step(wb(0, 32'h1));
      step(idle());
      chk("br_is_branch", commit_is_branch, 1);
      chk("br_value0", commit_value[0], 1);
      chk("br_flush", flush, 1);
      step(idle());
      chk("br_after_flag", commit_flag, 0);
      chk("br_after_tail", issue_rename, 0);
      for (int k = 0; k < 4; k++) step(idle());

      // correct prediction: no flush
      do_reset();
      step(iss(3, 1, 0, 1));
      step(wb(0, 32'h1));
      step(idle());
      chk("br_ok_flag", commit_flag, 1);
      chk("br_ok_noflush", flush, 0);

      // jalr
      do_reset();
      step(iss(1, 0, 1, 0));
      step(wb(0, 32'h1004));
      step(idle());
      chk("jalr_flag", commit_is_jalr, 1);
      chk("jalr_value", commit_value, 32'h1004);
      chk("jalr_flush", flush, 1);
      step(idle());

      // rdy low with a ready head
      do_reset();
      step(iss(4, 0, 0, 0));
      step(wb(0, 32'h33));
      for (int k = 0; k < 3; k++) begin
         step(mk(1, 6, 0, 0, 0, 0, 0, 0, 0));
         chk("rdylow_noflag", commit_flag, 0);
      end
      step(idle());
      chk("rdy_back_flag", commit_flag, 1);
      step(idle());
      chk("rdy_single_pulse", commit_flag, 0);

      // reset mid-operation
      step(iss(2, 0, 0, 0));
      step(wb(1, 32'h9));
      do_reset();
      step(idle());
      chk("midrst_noflag", commit_flag, 0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         in_t x;
         x = mk($urandom_range(1, 0) == 1, 5'($urandom),
                $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
                1'($urandom), $urandom_range(1, 0) == 1, 4'($urandom),
                $urandom, $urandom_range(9, 0) != 0);
         if (q.size() > 0 && $urandom_range(9, 0) < 7)
            x.wt = q[$urandom_range(q.size() - 1, 0)].tag;
         step(x);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer with 16 entries. It accepts instructions in program order from the issue stage and captures execution results written back out of order. It retires the head entry in order, driving the commit interface that the CDB broadcasts to the RS, LSB, register file and predictor. It also flags branch and jalr mispredictions so the front end can flush.

## Interface
Parameters:
- DEPTH, 16, number of entries. The rename tag width is fixed at 4 bits, so DEPTH must be 16.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- rdy, input, 1, global ready. When low, the block holds all state and drives no new commit.
- issue_valid, input, 1, allocate one entry this cycle.
- issue_dest, input, 5, architectural destination register.
- issue_is_branch, input, 1, entry is a conditional branch.
- issue_is_jalr, input, 1, entry is a jalr.
- issue_pred_jump, input, 1, predictor's taken guess for a branch.
- issue_rename, output, 4, tag for the entry being allocated; equals the tail index (combinational).
- rob_full, output, 1, count == 16 (combinational from the registered count).
- wb_valid, input, 1, an execution result is presented.
- wb_rename, input, 4, tag of the completing entry.
- wb_value, input, 32, result: ALU value, bit 0 = actual taken for a branch, or the target for a jalr.
- commit_flag, output, 1, one-cycle retire pulse.
- commit_value, output, 32, value of the retired entry.
- commit_rename, output, 4, tag of the retired entry.
- commit_dest, output, 5, destination of the retired entry.
- commit_is_branch, output, 1, retired entry is a branch.
- commit_is_jalr, output, 1, retired entry is a jalr.
- flush, output, 1, one-cycle pulse, coincident with commit_flag, requesting a pipeline flush.

## Operation
- State:
  - per entry: busy, ready, dest, is_branch, is_jalr, pred_jump, value.
  - head and tail: 4 bits, wrap modulo 16.
  - count: 5 bits, range 0..16.
- Allocate:
  - Condition: issue_valid && !rob_full && rdy && !flush.
  - Writes entry[tail] with busy=1, ready=0 and the issue fields.
  - tail increments.
  - Issue while full is ignored; upstream must hold the instruction.
- Writeback:
  - Condition: wb_valid && rdy && entry[wb_rename].busy.
  - Sets value=wb_value and ready=1.
  - A writeback to a non-busy entry is ignored.
- Commit:
  - Condition: count != 0 && entry[head].busy && entry[head].ready && rdy && !flush.
  - Registers commit_* from entry[head], clears busy, increments head.
  - At most one commit per cycle.
- Misprediction: when the committing entry is a branch with value[0] != pred_jump, or is any jalr, flush is registered high together with commit_flag.
- Flush: in the cycle flush is high:
  - head, tail and count go to 0 and all busy bits clear.
  - Issue and writeback in that cycle are discarded.
- Count update: count += alloc − commit. A simultaneous allocate and commit leaves count unchanged.

## Timing
- Reset (rst low, asynchronous):
  - commit_flag, flush, commit_is_branch, commit_is_jalr = 0.
  - commit_value, commit_rename, commit_dest = 0.
  - head, tail, count = 0; all busy and ready bits = 0.
- Issue to tag: issue_rename is valid in the same cycle. The entry is visible from the next edge.
- Writeback to commit:
  - The ready bit is registered, so a head entry written back in cycle N commits at edge N+1.
  - commit_flag is high during cycle N+1 through N+2.
  - A writeback and the ready check in the same cycle do not bypass.
- commit_flag is high for exactly one cycle per retired entry. Back-to-back ready entries give consecutive pulses.
- Full boundary:
  - count == 16 asserts rob_full even if a commit happens the same cycle; there is no bypass.
  - Wrap: tail 15 → 0 and head 15 → 0.
- rdy low: nothing changes and commit_flag/flush are 0 on the following cycle. Results presented while rdy is low are lost, so the producer must hold them.
- Reset mid-operation: all entries are dropped immediately, with no partial commit.

## Test plan
- Reset, then issue dest=5 (tag 0); writeback tag 0 with 0x0000_00AA → one cycle later: commit_flag=1, commit_rename=0, commit_dest=5, commit_value=0xAA, flush=0.
- Out-of-order completion:
  - Stimulus: issue tags 0, 1, 2; write back 2, then 1, then 0.
  - Response: no commit until tag 0 is ready, then three consecutive pulses with tags 0, 1, 2.
- Full/wrap:
  - Issue 16 entries: rob_full=1 and a 17th issue is ignored.
  - Complete and commit tag 0: rob_full=0.
  - Next issue gets issue_rename=0 (wrap).
- Branch mispredict:
  - Stimulus: issue branch with pred_jump=0, then two ALU ops; write back the branch with value 1.
  - Response: commit_is_branch=1, commit_value[0]=1, flush=1; the next cycle count=0 and the ALU ops never commit.
- jalr: issue jalr, write back 0x0000_1004 → commit_is_jalr=1, commit_value=0x1004, flush=1.
- rdy low for 3 cycles with a ready head → no commit pulse. After rdy returns high, a single commit pulse occurs.
